// File: rtl/alu_pkg.sv
// alu_pkg: state encodings and adder geometry shared by the sequential ALU units
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ADDER_BLK = 4;

endpackage

// File: rtl/seq_shift_add_mult_cbya.sv
// CBYA: combinational carry-skip adder; ripple inside each block, and a block whose bits
// all propagate passes its carry-in straight to the next block
module CBYA
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int NB = WIDTH / ADDER_BLK;

    always_comb begin
        logic c;
        logic rc;
        logic p;
        SUM = '0;
        c   = CIN;
        rc  = CIN;
        p   = 1'b1;
        for (int k = 0; k < NB; k++) begin
            rc = c;
            p  = 1'b1;
            for (int j = 0; j < ADDER_BLK; j++) begin
                SUM[k*ADDER_BLK+j] = A[k*ADDER_BLK+j] ^ B[k*ADDER_BLK+j] ^ rc;
                rc = (A[k*ADDER_BLK+j] & B[k*ADDER_BLK+j]) | (rc & (A[k*ADDER_BLK+j] ^ B[k*ADDER_BLK+j]));
                p  = p & (A[k*ADDER_BLK+j] ^ B[k*ADDER_BLK+j]);
            end
            c = p ? c : rc;
        end
        COUT = c;
        OVF  = (A[WIDTH-1] == B[WIDTH-1]) & (SUM[WIDTH-1] != A[WIDTH-1]);
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: unsigned shift-and-add multiplier, one CBYA add per cycle over WIDTH
// iterations, valid/ready handshakes on operand and result sides
module seq_shift_add_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic                 OVF
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH % ADDER_BLK != 0 || WIDTH < ADDER_BLK) begin : g_bad_width
        $error("seq_shift_add_mult: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, sum;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout, unused_add_ovf;

    CBYA #(.WIDTH(WIDTH)) u_add (
        .A   (hi_q),
        .B   (lo_q[0] ? mcand_q : '0),
        .CIN (1'b0),
        .SUM (sum),
        .COUT(cout),
        .OVF (unused_add_ovf)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (IN_VALID) begin
                mcand_d = A;
                hi_d    = '0;
                lo_d    = B;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                {hi_d, lo_d} = {cout, sum, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + 1'b1;
                state_d      = (cnt_q == CW'(WIDTH - 1)) ? ST_DONE : ST_RUN;
            end
            ST_DONE: state_d = OUT_READY ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE) & ~RST;
    assign OUT_VALID = (state_q == ST_DONE);
    assign PRODUCT   = {hi_q, lo_q};
    assign OVF       = |hi_q;

endmodule
